// File: rtl/ddr_word_muxer.sv
// rtl/ddr_word_muxer.sv - buffers (A,B) word pairs and serialises them A-then-B onto one bus
module ddr_word_muxer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_phase,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] held_b, held_b_nxt, data_nxt;
    logic             phase_nxt, valid_nxt;
    logic             push, pop, has_pair;

    // in_ready looks only at registered occupancy, so a pop never frees a slot on the same edge
    assign in_ready = !rst && (pending != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign has_pair = (pending != '0);

    always_comb begin
        state_nxt  = state;
        data_nxt   = out_data;
        phase_nxt  = out_phase;
        valid_nxt  = out_valid;
        held_b_nxt = held_b;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (has_pair) begin
                    pop        = 1'b1;
                    data_nxt   = mem_a[rd_ptr];
                    held_b_nxt = mem_b[rd_ptr];
                    phase_nxt  = 1'b1;
                    valid_nxt  = 1'b1;
                    state_nxt  = SEND_A;
                end
            end
            SEND_A: begin
                if (out_ready) begin
                    data_nxt  = held_b;
                    phase_nxt = 1'b0;
                    state_nxt = SEND_B;
                end
            end
            SEND_B: begin
                if (out_ready) begin
                    if (has_pair) begin
                        // chain straight into the next pair so the bus carries no bubble
                        pop        = 1'b1;
                        data_nxt   = mem_a[rd_ptr];
                        held_b_nxt = mem_b[rd_ptr];
                        phase_nxt  = 1'b1;
                        state_nxt  = SEND_A;
                    end else begin
                        valid_nxt = 1'b0;
                        phase_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                valid_nxt = 1'b0;
                phase_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_phase <= 1'b0;
            held_b    <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_phase <= phase_nxt;
            held_b    <= held_b_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   pending <= pending + CW'(1);
                2'b01:   pending <= pending - CW'(1);
                default: pending <= pending;
            endcase
        end
    end

    // payload storage needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end
endmodule

// File: tb/tb_ddr_word_muxer.sv
// tb/tb_ddr_word_muxer.sv - directed and random self-checking bench for ddr_word_muxer
module tb_ddr_word_muxer;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 2;
    localparam int NPAIRS = 10000;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a = '0;
    logic [WIDTH-1:0]       in_b = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [WIDTH-1:0]       out_data;
    logic                   out_phase;
    logic [$clog2(DEPTH):0] pending;

    int tests = 0;
    int fails = 0;

    ddr_word_muxer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_phase(out_phase), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic ph);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_phase"}, 32'(out_phase), 32'(ph));
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_w;
    int sent, got;

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_phase", 32'(out_phase), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // single pair, out_ready high
        in_valid = 1'b1; in_a = 32'h1111_1111; in_b = 32'h2222_2222; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t2_no_bypass", 32'(out_valid), 32'd0);
        chk("t2_pending", 32'(pending), 32'd1);
        @(negedge clk); chk_out("t2_a", 32'h1111_1111, 1'b1);
        @(negedge clk); chk_out("t2_b", 32'h2222_2222, 1'b0);
        @(negedge clk); chk("t2_idle", 32'(out_valid), 32'd0);

        // back-to-back pairs (1,2),(3,4),(5,6)
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 3);
            in_a = 32'(2 * i + 1);
            in_b = 32'(2 * i + 2);
            @(negedge clk);
            if (i >= 1 && i <= 6) chk_out($sformatf("t3_w%0d", i), 32'(i), (i % 2) == 1);
            if (i == 2) begin
                chk("t3_full_pending", 32'(pending), 32'(DEPTH));
                chk("t3_full_in_ready", 32'(in_ready), 32'd0);
            end
            if (i == 7) chk("t3_idle", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;

        // backpressure during SEND_B
        in_valid = 1'b1; in_a = 32'hCAFE_0001; in_b = 32'hDEAD_BEEF; out_ready = 1'b0;
        @(negedge clk);
        in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0;
        @(negedge clk); chk_out("t4_a", 32'hCAFE_0001, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); chk_out("t4_b", 32'hDEAD_BEEF, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk_out($sformatf("t4_hold%0d", i), 32'hDEAD_BEEF, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk); chk_out("t4_next_a", 32'h1234_5678, 1'b1);
        @(negedge clk); chk_out("t4_next_b", 32'h9ABC_DEF0, 1'b0);
        @(negedge clk); chk("t4_idle", 32'(out_valid), 32'd0);

        // full FIFO with pop and offered push on the same edge
        in_valid = 1'b1; in_a = 32'h5000_0001; in_b = 32'h5000_0002; out_ready = 1'b0;
        @(negedge clk);
        in_a = 32'h5000_0003; in_b = 32'h5000_0004;
        @(negedge clk);
        in_a = 32'h5000_0005; in_b = 32'h5000_0006;
        @(negedge clk);
        chk("t5_full_pending", 32'(pending), 32'd2);
        chk("t5_full_in_ready", 32'(in_ready), 32'd0);
        chk_out("t5_a1", 32'h5000_0001, 1'b1);
        in_a = 32'h5000_0007; in_b = 32'h5000_0008; out_ready = 1'b1;
        @(negedge clk);
        chk_out("t5_b1", 32'h5000_0002, 1'b0);
        chk("t5_still_full", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk_out("t5_a2", 32'h5000_0003, 1'b1);
        chk("t5_pop_pending", 32'(pending), 32'(DEPTH - 1));
        chk("t5_pop_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("t5_b2", 32'h5000_0004, 1'b0);
        chk("t5_refill_pending", 32'(pending), 32'd2);
        @(negedge clk); chk_out("t5_a3", 32'h5000_0005, 1'b1);
        @(negedge clk); chk_out("t5_b3", 32'h5000_0006, 1'b0);
        @(negedge clk); chk_out("t5_a4", 32'h5000_0007, 1'b1);
        chk("t5_drain_pending", 32'(pending), 32'd0);
        @(negedge clk); chk_out("t5_b4", 32'h5000_0008, 1'b0);
        @(negedge clk); chk("t5_idle", 32'(out_valid), 32'd0);

        // reset asserted mid-SEND_A with a buffered pair
        in_valid = 1'b1; in_a = 32'hAAAA_AAAA; in_b = 32'hBBBB_BBBB; out_ready = 1'b0;
        @(negedge clk);
        in_a = 32'hCCCC_CCCC; in_b = 32'hDDDD_DDDD;
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("t1_a", 32'hAAAA_AAAA, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t1_valid", 32'(out_valid), 32'd0);
        chk("t1_data", out_data, 32'd0);
        chk("t1_phase", 32'(out_phase), 32'd0);
        chk("t1_pending", 32'(pending), 32'd0);
        chk("t1_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t1_quiet%0d", i), 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1; in_a = 32'h7777_0001; in_b = 32'h7777_0002;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); chk_out("t1_fresh_a", 32'h7777_0001, 1'b1);
        @(negedge clk); chk_out("t1_fresh_b", 32'h7777_0002, 1'b0);
        @(negedge clk); chk("t1_idle", 32'(out_valid), 32'd0);

        // random traffic against a queue scoreboard
        sent = 0; got = 0;
        for (int c = 0; c < 80000 && got < 2 * NPAIRS; c++) begin
            in_valid  = (sent < NPAIRS) && ($urandom_range(0, 3) != 0);
            in_a      = $urandom;
            in_b      = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                q.push_back(in_a);
                q.push_back(in_b);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_word", out_data, 32'hxxxx_xxxx);
                end else begin
                    exp_w = q.pop_front();
                    chk("rand_data", out_data, exp_w);
                    chk("rand_phase", 32'(out_phase), 32'((got % 2) == 0));
                end
                got++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("rand_words_received", 32'(got), 32'(2 * NPAIRS));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
